// File: rtl/rvcore_pkg.sv
// Shared core definitions: writeback requester encoding and
// the default starvation threshold for the writeback arbiter.
package rvcore_pkg;

   typedef enum logic [1:0] {
      REQ_ALU  = 2'd0,
      REQ_LSU  = 2'd1,
      REQ_MDU  = 2'd2,
      REQ_NONE = 2'd3
   } req_e;

   localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// Register busy-bit scoreboard for long-latency destinations,
// with RAW/WAW hazard detection on the issuing instruction.
module rf_scoreboard
   import rvcore_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       issue_valid,
   input  logic [4:0] issue_rd,
   input  logic       issue_long,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       clr_valid,
   input  logic [4:0] clr_rd,
   output logic       rs1_busy,
   output logic       rs2_busy,
   output logic       stall
);

   logic [31:0] r_busy;
   logic [31:0] w_busy_nxt;
   logic [31:0] w_set_mask;
   logic [31:0] w_clr_mask;
   logic        w_set;

   assign rs1_busy = r_busy[rs1];
   assign rs2_busy = r_busy[rs2];
   assign stall    = issue_valid &&
                     (rs1_busy || rs2_busy || r_busy[issue_rd]);

   assign w_set = issue_valid && !stall && issue_long &&
                  (issue_rd != 5'd0);

   // Set is applied after clear so it wins on the same rd.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (w_set)
         w_set_mask[issue_rd] = 1'b1;
      if (clr_valid)
         w_clr_mask[clr_rd] = 1'b1;
      if (flush)
         w_busy_nxt = '0;
      else
         w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: ALU > LSU > MDU with
// starvation promotion, plus the long-latency scoreboard.
module rf_wb_arbiter
   import rvcore_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic            issue_long,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            stall,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_wdata,
   output logic            alu_ready,
   input  logic            lsu_valid,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_wdata,
   output logic            lsu_ready,
   input  logic            mdu_valid,
   input  logic [4:0]      mdu_rd,
   input  logic [XLEN-1:0] mdu_wdata,
   output logic            mdu_ready,
   input  logic            flush,
   output logic            rf_we,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wdata
);

   localparam logic [2:0] LIM = 3'(STARVE_LIMIT);

   logic [2:0] r_lsu_cnt;
   logic [2:0] r_mdu_cnt;
   logic       w_lsu_prom;
   logic       w_mdu_prom;
   logic       w_clr_valid;
   logic [4:0] w_clr_rd;
   logic [4:0] w_rd;
   req_e       w_gnt;

   assign w_lsu_prom = lsu_valid && (r_lsu_cnt == LIM);
   assign w_mdu_prom = mdu_valid && (r_mdu_cnt == LIM);

   // Grants are masked during reset so no handshake can complete.
   always_comb begin
      w_gnt = REQ_NONE;
      if (!rst_n)
         w_gnt = REQ_NONE;
      else if (w_lsu_prom)
         w_gnt = REQ_LSU;
      else if (w_mdu_prom)
         w_gnt = REQ_MDU;
      else if (alu_valid)
         w_gnt = REQ_ALU;
      else if (lsu_valid)
         w_gnt = REQ_LSU;
      else if (mdu_valid)
         w_gnt = REQ_MDU;
   end

   always_comb begin
      alu_ready = (w_gnt == REQ_ALU);
      lsu_ready = (w_gnt == REQ_LSU);
      mdu_ready = (w_gnt == REQ_MDU);
      w_rd      = '0;
      rf_wdata  = '0;
      unique case (w_gnt)
         REQ_ALU: begin
            w_rd     = alu_rd;
            rf_wdata = alu_wdata;
         end
         REQ_LSU: begin
            w_rd     = lsu_rd;
            rf_wdata = lsu_wdata;
         end
         REQ_MDU: begin
            w_rd     = mdu_rd;
            rf_wdata = mdu_wdata;
         end
         default: ;
      endcase
      rf_rd = w_rd;
      rf_we = (w_gnt != REQ_NONE) && (w_rd != 5'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_lsu_cnt <= '0;
      else if (!lsu_valid || lsu_ready)
         r_lsu_cnt <= '0;
      else if (r_lsu_cnt != LIM)
         r_lsu_cnt <= r_lsu_cnt + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_mdu_cnt <= '0;
      else if (!mdu_valid || mdu_ready)
         r_mdu_cnt <= '0;
      else if (r_mdu_cnt != LIM)
         r_mdu_cnt <= r_mdu_cnt + 3'd1;
   end

   // Only long-latency completions retire a busy bit.
   assign w_clr_valid = lsu_ready || mdu_ready;
   assign w_clr_rd    = lsu_ready ? lsu_rd : mdu_rd;

   rf_scoreboard u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_long  (issue_long),
      .rs1         (rs1),
      .rs2         (rs2),
      .clr_valid   (w_clr_valid),
      .clr_rd      (w_clr_rd),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .stall       (stall)
   );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized bench for rf_wb_arbiter against a behavioural
// model of arbitration, starvation and busy tracking.
module tb_rf_wb_arbiter;

   localparam int SL = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_long;
   logic [4:0]  issue_rd, rs1, rs2;
   logic        rs1_busy, rs2_busy, stall;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_wdata;
   logic        lsu_valid, lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_wdata;
   logic        mdu_valid, mdu_ready;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_wdata;
   logic        flush;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 0;

   int          lc, mc;
   logic [31:0] mb;

   rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_long(issue_long), .rs1(rs1), .rs2(rs2),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall),
      .alu_valid(alu_valid), .alu_rd(alu_rd),
      .alu_wdata(alu_wdata), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd),
      .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd),
      .mdu_wdata(mdu_wdata), .mdu_ready(mdu_ready),
      .flush(flush),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Model: g = granted requester (0 ALU, 1 LSU, 2 MDU, 3 none)
   always @(negedge clk) begin : mdl
      int          g;
      logic [4:0]  erd;
      logic [31:0] ewd;
      logic        est;
      if (chk_en) begin
         if (!rst_n) begin
            lc = 0;
            mc = 0;
            mb = '0;
         end
         g = 3;
         if (rst_n) begin
            if (lsu_valid && lc == SL)      g = 1;
            else if (mdu_valid && mc == SL) g = 2;
            else if (alu_valid)             g = 0;
            else if (lsu_valid)             g = 1;
            else if (mdu_valid)             g = 2;
         end
         erd = (g == 0) ? alu_rd : (g == 1) ? lsu_rd :
               (g == 2) ? mdu_rd : 5'd0;
         ewd = (g == 0) ? alu_wdata : (g == 1) ? lsu_wdata :
               (g == 2) ? mdu_wdata : 32'd0;
         est = issue_valid && (mb[rs1] || mb[rs2] || mb[issue_rd]);
         chk("m_alu_ready", 32'(alu_ready), 32'(g == 0));
         chk("m_lsu_ready", 32'(lsu_ready), 32'(g == 1));
         chk("m_mdu_ready", 32'(mdu_ready), 32'(g == 2));
         chk("m_rf_we", 32'(rf_we), 32'(g != 3 && erd != 0));
         chk("m_rf_rd", 32'(rf_rd), 32'(erd));
         chk("m_rf_wdata", rf_wdata, ewd);
         chk("m_rs1_busy", 32'(rs1_busy), 32'(mb[rs1]));
         chk("m_rs2_busy", 32'(rs2_busy), 32'(mb[rs2]));
         chk("m_stall", 32'(stall), 32'(est));
         if (rst_n) begin
            lc = (lsu_valid && g != 1) ? ((lc < SL) ? lc + 1 : SL) : 0;
            mc = (mdu_valid && g != 2) ? ((mc < SL) ? mc + 1 : SL) : 0;
            if (flush)
               mb = '0;
            else begin
               if (g == 1 || g == 2)
                  mb[erd] = 1'b0;
               if (issue_valid && !est && issue_long && issue_rd != 0)
                  mb[issue_rd] = 1'b1;
               mb[0] = 1'b0;
            end
         end
      end
   end

   initial begin
      logic ah, lh, mh;
      rst_n = 0; flush = 0;
      issue_valid = 1; issue_long = 1; issue_rd = 5'd4;
      rs1 = 5'd5; rs2 = 5'd6;
      alu_valid = 1; alu_rd = 5'd1; alu_wdata = 32'h1;
      lsu_valid = 1; lsu_rd = 5'd2; lsu_wdata = 32'h2;
      mdu_valid = 1; mdu_rd = 5'd3; mdu_wdata = 32'h3;
      chk_en = 1;
      #2;
      chk("rst_alu_ready", 32'(alu_ready), 0);
      chk("rst_lsu_ready", 32'(lsu_ready), 0);
      chk("rst_mdu_ready", 32'(mdu_ready), 0);
      chk("rst_rf_we", 32'(rf_we), 0);
      chk("rst_rs1_busy", 32'(rs1_busy), 0);
      nxt(); nxt();
      rst_n = 1;
      alu_valid = 0; lsu_valid = 0; mdu_valid = 0; issue_valid = 0;
      nxt();
      // all three request: ALU first, then starvation order
      alu_valid = 1; alu_rd = 5'd5; alu_wdata = 32'h11;
      lsu_valid = 1; lsu_rd = 5'd6; lsu_wdata = 32'h22;
      mdu_valid = 1; mdu_rd = 5'd7; mdu_wdata = 32'h33;
      @(negedge clk);
      chk("all3_alu_ready", 32'(alu_ready), 1);
      chk("all3_lsu_ready", 32'(lsu_ready), 0);
      chk("all3_mdu_ready", 32'(mdu_ready), 0);
      chk("all3_rf_we", 32'(rf_we), 1);
      chk("all3_rf_rd", 32'(rf_rd), 5);
      for (int c = 2; c <= 4; c++) begin
         nxt();
         @(negedge clk);
         chk("hold_alu_ready", 32'(alu_ready), 1);
      end
      nxt();
      @(negedge clk);
      chk("starve_lsu_ready", 32'(lsu_ready), 1);
      chk("starve_alu_ready", 32'(alu_ready), 0);
      chk("starve_rf_rd", 32'(rf_rd), 6);
      nxt();
      @(negedge clk);
      chk("starve_mdu_ready", 32'(mdu_ready), 1);
      chk("starve_mdu_rd", 32'(rf_rd), 7);
      nxt();
      @(negedge clk);
      chk("cnt_clr_alu_ready", 32'(alu_ready), 1);
      nxt();
      alu_valid = 0; lsu_valid = 0; mdu_valid = 0;
      // RAW hazard on a long-latency destination
      issue_valid = 1; issue_long = 1; issue_rd = 5'd9;
      rs1 = 5'd0; rs2 = 5'd0;
      @(negedge clk);
      chk("iss9_stall", 32'(stall), 0);
      nxt();
      issue_long = 0; issue_rd = 5'd10; rs1 = 5'd9;
      @(negedge clk);
      chk("raw9_stall", 32'(stall), 1);
      chk("raw9_rs1_busy", 32'(rs1_busy), 1);
      nxt();
      issue_valid = 0;
      lsu_valid = 1; lsu_rd = 5'd9; lsu_wdata = 32'h99;
      @(negedge clk);
      chk("wb9_lsu_ready", 32'(lsu_ready), 1);
      nxt();
      lsu_valid = 0; issue_valid = 1;
      @(negedge clk);
      chk("wb9_stall", 32'(stall), 0);
      nxt();
      // set beats clear on the same rd, flush then wipes it
      issue_long = 1; issue_rd = 5'd3; rs1 = 5'd0;
      mdu_valid = 1; mdu_rd = 5'd3; mdu_wdata = 32'h3;
      @(negedge clk);
      chk("setclr_mdu_ready", 32'(mdu_ready), 1);
      chk("setclr_stall", 32'(stall), 0);
      nxt();
      issue_valid = 0; mdu_valid = 0; rs1 = 5'd3; flush = 1;
      @(negedge clk);
      chk("setclr_busy3", 32'(rs1_busy), 1);
      nxt();
      flush = 0;
      @(negedge clk);
      chk("flush_busy3", 32'(rs1_busy), 0);
      nxt();
      // write to x0 and mid-stream reset
      alu_valid = 1; alu_rd = 5'd0; alu_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("x0_alu_ready", 32'(alu_ready), 1);
      chk("x0_rf_we", 32'(rf_we), 0);
      nxt();
      lsu_valid = 1; mdu_valid = 1;
      rst_n = 0;
      #1;
      chk("midrst_alu_ready", 32'(alu_ready), 0);
      chk("midrst_lsu_ready", 32'(lsu_ready), 0);
      chk("midrst_mdu_ready", 32'(mdu_ready), 0);
      chk("midrst_rf_we", 32'(rf_we), 0);
      nxt();
      rst_n = 1; alu_rd = 5'd12;
      @(negedge clk);
      chk("postrst_alu_ready", 32'(alu_ready), 1);
      // randomized traffic honouring valid/ready hold rules
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         ah = alu_valid && !alu_ready;
         lh = lsu_valid && !lsu_ready;
         mh = mdu_valid && !mdu_ready;
         nxt();
         if (!ah) begin
            alu_valid = ($urandom_range(0, 99) < 80);
            alu_rd = 5'($urandom_range(0, 7));
            alu_wdata = $urandom;
         end
         if (!lh) begin
            lsu_valid = ($urandom_range(0, 99) < 50);
            lsu_rd = 5'($urandom_range(0, 7));
            lsu_wdata = $urandom;
         end
         if (!mh) begin
            mdu_valid = ($urandom_range(0, 99) < 40);
            mdu_rd = 5'($urandom_range(0, 7));
            mdu_wdata = $urandom;
         end
         issue_valid = 1'($urandom_range(0, 1));
         issue_long = 1'($urandom_range(0, 1));
         issue_rd = 5'($urandom_range(0, 7));
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         flush = ($urandom_range(0, 99) < 4);
      end
      @(negedge clk);
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The parameter XLEN SHALL default to 32 and set the write-data width.
REQ-002 The parameter STARVE_LIMIT SHALL default to 4 and set the missed-grant count (1..7) that promotes a requester.
REQ-003 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates on its rising edge.
REQ-004 The port rst_n SHALL be an input, 1 bit wide, and SHALL be the reset: asynchronous, active-low.
REQ-005 The ports issue_valid (in, 1), issue_rd (in, 5) and issue_long (in, 1) SHALL carry an instruction issuing this cycle; issue_long marks an LSU/MDU destination.
REQ-006 The ports rs1 and rs2 (in, 5) SHALL carry the issuing instruction's source indices.
REQ-007 The outputs rs1_busy, rs2_busy and stall (1 each) SHALL be the scoreboard hazard outputs.
REQ-008 The ports alu_valid (in, 1), alu_rd (in, 5), alu_wdata (in, XLEN) and alu_ready (out, 1) SHALL form the ALU writeback request.
REQ-009 The ports lsu_valid, lsu_rd, lsu_wdata and lsu_ready SHALL form the load-unit writeback request, with the same widths as ALU.
REQ-010 The ports mdu_valid, mdu_rd, mdu_wdata and mdu_ready SHALL form the mul/div writeback request, with the same widths as ALU.
REQ-011 The port flush SHALL be an input, 1 bit wide, that clears the scoreboard synchronously.
REQ-012 The outputs rf_we (1), rf_rd (5) and rf_wdata (XLEN) SHALL drive the register file write port.

Function
REQ-013 At most one ready SHALL be high per cycle; ready is combinational from the current valids and registered state (zero-latency grant).
REQ-014 A transfer SHALL occur on a cycle where valid&&ready; the requester holds rd/wdata stable until then.
REQ-015 Default priority SHALL be ALU > LSU > MDU.
REQ-016 The LSU and MDU SHALL each own a 3-bit counter: +1 when valid && !ready; cleared when ready or !valid; saturates at STARVE_LIMIT.
REQ-017 A requester whose counter == STARVE_LIMIT SHALL be promoted above the ALU; if both are promoted, LSU wins.
REQ-018 rf_we SHALL equal the granted valid; rf_rd/rf_wdata are muxed from the granted requester; all zero when none is granted.
REQ-019 A granted write with rd==0 SHALL complete the handshake with rf_we forced 0.
REQ-020 The scoreboard SHALL hold 32 busy bits; bit 0 is hardwired 0.
REQ-021 Busy set SHALL happen on issue_valid && !stall && issue_long && issue_rd!=0.
REQ-022 Busy clear SHALL happen on a completed LSU or MDU transfer to rd; ALU transfers never clear.
REQ-023 On a simultaneous set and clear of the same rd, set SHALL win.
REQ-024 rsN_busy SHALL equal registered busy[rsN]; no same-cycle bypass from the granted write.
REQ-025 stall SHALL equal issue_valid && (rs1_busy || rs2_busy || busy[issue_rd]); the last term is the WAW check.
REQ-026 When flush is high, all busy bits SHALL clear next edge, overriding same-cycle sets; in-flight LSU/MDU writebacks are still arbitrated and written.

Reset
REQ-027 While rst_n is low, all busy bits and starvation counters SHALL be 0.
REQ-028 While rst_n is low, all readies and rf_we SHALL be 0 regardless of valids.
REQ-029 On reset release mid-operation, the block SHALL resume with default priority and pending valids are arbitrated normally.

Structure
REQ-030 The shared rvcore package SHALL hold the requester encoding (ALU=0, LSU=1, MDU=2) and the STARVE_LIMIT default.
REQ-031 The scoreboard SHALL be a sub-module rf_scoreboard containing the busy bits, set/clear/flush logic and hazard outputs; the arbiter and counters stay in rf_wb_arbiter.

Verification
REQ-032 The bench SHALL cover: alu_valid, lsu_valid, mdu_valid all high with rd 5/6/7 -> alu_ready only; rf_we=1, rf_rd=5.
REQ-033 The bench SHALL cover: alu_valid held high for 4 cycles with lsu_valid high -> lsu_ready on cycle 5 ahead of the ALU; counter back to 0.
REQ-034 The bench SHALL cover: LSU and MDU both at the limit -> LSU granted first, then MDU granted next cycle (its counter still at limit).
REQ-035 The bench SHALL cover: issue_long with rd=9 -> next cycle, issue with rs1=9 gives stall=1; lsu write to rd 9 completes -> stall=0 next cycle.
REQ-036 The bench SHALL cover: same-cycle issue_long rd=3 and mdu write rd=3 -> busy[3]=1; flush -> busy[3]=0 next cycle.
REQ-037 The bench SHALL cover: alu write with rd=0 and wdata=0xDEADBEEF -> alu_ready=1, rf_we=0; rst_n low mid-stream -> all readies 0 immediately.
